// File: rtl/apb_pkg.sv
// Shared APB types and the initiator state encoding.
package apb_pkg;

  localparam int unsigned ApbAddrW = 32;
  localparam int unsigned ApbDataW = 32;
  localparam int unsigned ApbStrbW = ApbDataW / 8;

  typedef logic [ApbAddrW-1:0] apb_addr_t;
  typedef logic [ApbDataW-1:0] apb_data_t;
  typedef logic [ApbStrbW-1:0] strb_t;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StAccess,
    StResp
  } apb_mst_state_e;

  // Reads never carry byte strobes on the bus.
  function automatic strb_t bus_strb(input logic write, input strb_t strb);
    return write ? strb : '0;
  endfunction

endpackage

// File: rtl/apb_master.sv
// APB4 initiator: turns a valid/ready command stream into single SETUP/ACCESS transfers
// and returns one read-data/error response per command, with an optional ACCESS timeout.
module apb_master
  import apb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic      pclk_i,
  input  logic      preset_i,
  input  logic      req_valid_i,
  output logic      req_ready_o,
  input  apb_addr_t req_addr_i,
  input  logic      req_write_i,
  input  apb_data_t req_wdata_i,
  input  strb_t     req_strb_i,
  output logic      rsp_valid_o,
  input  logic      rsp_ready_i,
  output apb_data_t rsp_rdata_o,
  output logic      rsp_slverr_o,
  output apb_addr_t paddr_o,
  output logic      psel_o,
  output logic      penable_o,
  output logic      pwrite_o,
  output apb_data_t pwdata_o,
  output strb_t     pstrb_o,
  input  logic      pready_i,
  input  apb_data_t prdata_i,
  input  logic      pslverr_i
);

  // Keep the counter at least one bit wide so TIMEOUT_CYCLES = 0 still elaborates.
  localparam int unsigned CntW = (CNT_W < 1) ? 1 : CNT_W;
  localparam logic [CntW-1:0] CntLast =
      CntW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  apb_mst_state_e  state_q;
  logic [CntW-1:0] cnt_q;
  logic            req_ready_q;
  logic            rsp_valid_q;
  apb_data_t       rsp_rdata_q;
  logic            rsp_slverr_q;
  apb_addr_t       paddr_q;
  logic            psel_q;
  logic            penable_q;
  logic            pwrite_q;
  apb_data_t       pwdata_q;
  strb_t           pstrb_q;
  logic            timeout_hit;

  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CntLast);

  always_ff @(posedge pclk_i) begin
    if (preset_i) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      req_ready_q  <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      rsp_slverr_q <= 1'b0;
      paddr_q      <= '0;
      psel_q       <= 1'b0;
      penable_q    <= 1'b0;
      pwrite_q     <= 1'b0;
      pwdata_q     <= '0;
      pstrb_q      <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (req_valid_i) begin
            paddr_q     <= req_addr_i;
            pwrite_q    <= req_write_i;
            pwdata_q    <= req_wdata_i;
            pstrb_q     <= bus_strb(req_write_i, req_strb_i);
            psel_q      <= 1'b1;
            req_ready_q <= 1'b0;
            state_q     <= StSetup;
          end
        end
        StSetup: begin
          penable_q <= 1'b1;
          cnt_q     <= '0;
          state_q   <= StAccess;
        end
        StAccess: begin
          // A ready slave takes priority over a timeout landing on the same cycle.
          if (pready_i) begin
            rsp_rdata_q  <= pwrite_q ? '0 : prdata_i;
            rsp_slverr_q <= pslverr_i;
            psel_q       <= 1'b0;
            penable_q    <= 1'b0;
            rsp_valid_q  <= 1'b1;
            state_q      <= StResp;
          end else if (timeout_hit) begin
            rsp_rdata_q  <= '0;
            rsp_slverr_q <= 1'b1;
            psel_q       <= 1'b0;
            penable_q    <= 1'b0;
            rsp_valid_q  <= 1'b1;
            state_q      <= StResp;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StResp: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: begin
          psel_q      <= 1'b0;
          penable_q   <= 1'b0;
          rsp_valid_q <= 1'b0;
          req_ready_q <= 1'b1;
          state_q     <= StIdle;
        end
      endcase
    end
  end

  assign req_ready_o  = req_ready_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_rdata_o  = rsp_rdata_q;
  assign rsp_slverr_o = rsp_slverr_q;
  assign paddr_o      = paddr_q;
  assign psel_o       = psel_q;
  assign penable_o    = penable_q;
  assign pwrite_o     = pwrite_q;
  assign pwdata_o     = pwdata_q;
  assign pstrb_o      = pstrb_q;

endmodule

// File: tb/tb_apb_master.sv
// Scoreboard bench for apb_master: a driver issues commands, a slave model answers with
// planned wait states, and a monitor checks every response against the queued expectation.
module tb_apb_master;

  localparam int T = 8;

  typedef struct {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          waits;
    logic [31:0] rdata;
    logic        err;
  } cmd_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
    int          lat;
    int          stall;
  } exp_t;

  logic        pclk = 1'b0;
  logic        preset;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_strb;
  logic        rsp_valid, rsp_ready, rsp_slverr;
  logic [31:0] rsp_rdata;
  logic [31:0] paddr, pwdata, prdata;
  logic        psel, penable, pwrite, pready, pslverr;
  logic [3:0]  pstrb;

  int   n_tests = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   n_acc = 0;
  int   n_hs = 0;
  int   n_drop = 0;
  int   last_hs = -1;
  int   rst_epoch = 0;
  cmd_t slv_q[$];
  exp_t exp_q[$];

  apb_master #(.TIMEOUT_CYCLES(T)) dut (
    .pclk_i      (pclk),
    .preset_i    (preset),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_addr_i  (req_addr),
    .req_write_i (req_write),
    .req_wdata_i (req_wdata),
    .req_strb_i  (req_strb),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_rdata_o (rsp_rdata),
    .rsp_slverr_o(rsp_slverr),
    .paddr_o     (paddr),
    .psel_o      (psel),
    .penable_o   (penable),
    .pwrite_o    (pwrite),
    .pwdata_o    (pwdata),
    .pstrb_o     (pstrb),
    .pready_i    (pready),
    .prdata_i    (prdata),
    .pslverr_i   (pslverr)
  );

  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void check_apb(input string tag, input logic [31:0] ea, input logic ew,
                                    input logic [31:0] ed, input logic [3:0] es);
    chk({tag, "_paddr"}, paddr, ea);
    chk({tag, "_pwrite"}, 32'(pwrite), 32'(ew));
    chk({tag, "_pwdata"}, pwdata, ed);
    chk({tag, "_pstrb"}, 32'(pstrb), 32'(es));
  endfunction

  function automatic cmd_t mk(input logic [31:0] a, input logic w, input logic [31:0] d,
                              input logic [3:0] s, input int waits, input logic [31:0] rd,
                              input logic er);
    cmd_t c;
    c.addr = a; c.write = w; c.wdata = d; c.strb = s;
    c.waits = waits; c.rdata = rd; c.err = er;
    return c;
  endfunction

  task automatic check_reset(input string tag);
    check_apb(tag, 32'h0, 1'b0, 32'h0, 4'h0);
    chk({tag, "_psel"}, 32'(psel), 32'd0);
    chk({tag, "_penable"}, 32'(penable), 32'd0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 32'h0);
    chk({tag, "_rsp_slverr"}, 32'(rsp_slverr), 32'd0);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
  endtask

  // Called on a negedge; returns on the negedge after the command was accepted.
  task automatic send(input cmd_t c, input int stall);
    exp_t e;
    bit   to, done;
    int   n;
    logic exp_rdy;
    req_valid = 1'b1; req_addr = c.addr; req_write = c.write;
    req_wdata = c.wdata; req_strb = c.strb;
    done = 0; n = 0;
    while (!done) begin
      // The master is free once every accepted command has had its response taken.
      exp_rdy = (n_hs + n_drop == n_acc) && (last_hs < cyc);
      chk("req_ready", 32'(req_ready), 32'(exp_rdy));
      if (req_ready) begin
        to      = (c.waits >= T);
        e.rdata = (to || c.write) ? 32'h0 : c.rdata;
        e.err   = to ? 1'b1 : c.err;
        e.lat   = 3 + (to ? T - 1 : c.waits);
        e.acc   = cyc;
        e.stall = stall;
        exp_q.push_back(e);
        slv_q.push_back(c);
        n_acc++;
        done = 1;
      end else if (n >= 100) begin
        n_tests++; n_fail++;
        $display("FAIL accept_timeout: got no accept in %0d cycles, expected accept", n);
        done = 1;
      end
      @(negedge pclk);
      n++;
    end
    req_valid = 1'b0;
    req_addr  = $urandom; req_wdata = $urandom;
    req_write = 1'($urandom_range(0, 1)); req_strb = 4'($urandom_range(0, 15));
  endtask

  task automatic wait_idle();
    int n = 0;
    while (n_hs + n_drop != n_acc && n < 500) begin
      @(negedge pclk);
      n++;
    end
    chk("drain", 32'(n_hs + n_drop), 32'(n_acc));
    @(negedge pclk);
  endtask

  initial begin : slave
    cmd_t        cur;
    int          acc_n, ep;
    bit          in_acc;
    logic [31:0] l_addr, l_wdata;
    logic        l_write;
    logic [3:0]  l_strb;
    pready = 1'b0; prdata = '0; pslverr = 1'b0;
    cur = mk(32'h0, 1'b0, 32'h0, 4'h0, 0, 32'h0, 1'b0);
    acc_n = 0; ep = 0; in_acc = 0;
    l_addr = '0; l_wdata = '0; l_write = 1'b0; l_strb = '0;
    forever begin
      @(negedge pclk);
      if (psel && penable) begin
        if (!in_acc) begin
          in_acc = 1; acc_n = 0;
          if (slv_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL unexpected_xfer: got an APB access, expected none");
          end else begin
            cur = slv_q.pop_front();
          end
          l_addr = cur.addr; l_write = cur.write; l_wdata = cur.wdata;
          l_strb = cur.write ? cur.strb : 4'h0;
        end else begin
          acc_n++;
        end
        check_apb("access", l_addr, l_write, l_wdata, l_strb);
        chk("access_len", 32'(acc_n < T), 32'd1);
        if (acc_n == cur.waits) begin
          pready = 1'b1; prdata = cur.rdata; pslverr = cur.err;
        end else begin
          pready = 1'b0; prdata = $urandom; pslverr = 1'($urandom_range(0, 1));
        end
      end else begin
        in_acc = 0;
        if (ep != rst_epoch) begin
          ep = rst_epoch;
          l_addr = '0; l_wdata = '0; l_write = 1'b0; l_strb = '0;
        end
        if (!psel) check_apb("idle_hold", l_addr, l_write, l_wdata, l_strb);
        // Noise outside ACCESS must have no effect.
        pready = 1'($urandom_range(0, 1)); prdata = $urandom;
        pslverr = 1'($urandom_range(0, 1));
      end
    end
  end

  initial begin : monitor
    exp_t cur;
    bit   seen;
    int   hold;
    rsp_ready = 1'b0; seen = 0; hold = 0;
    cur.rdata = '0; cur.err = 1'b0; cur.acc = 0; cur.lat = 0; cur.stall = 0;
    forever begin
      @(negedge pclk);
      if (rsp_valid) begin
        chk("busy_req_ready", 32'(req_ready), 32'd0);
        if (!seen && exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_rsp: got rsp_valid=1, expected no response");
          rsp_ready = 1'b1;
        end else begin
          if (!seen) begin
            cur = exp_q.pop_front();
            seen = 1; hold = cur.stall;
            chk("rsp_rdata", rsp_rdata, cur.rdata);
            chk("rsp_slverr", 32'(rsp_slverr), 32'(cur.err));
            chk("rsp_latency", 32'(cyc - cur.acc), 32'(cur.lat));
          end else begin
            chk("rsp_hold_rdata", rsp_rdata, cur.rdata);
            chk("rsp_hold_slverr", 32'(rsp_slverr), 32'(cur.err));
          end
          if (hold > 0) begin
            rsp_ready = 1'b0;
            hold--;
          end else begin
            rsp_ready = ($urandom_range(0, 3) != 0);
          end
          if (rsp_ready) begin
            seen = 0; n_hs++; last_hs = cyc;
          end
        end
      end else begin
        rsp_ready = 1'($urandom_range(0, 1));
      end
    end
  end

  initial begin : driver
    int r, w;
    preset = 1'b1; req_valid = 1'b0; req_addr = '0; req_write = 1'b0;
    req_wdata = '0; req_strb = '0;
    repeat (3) @(negedge pclk);
    check_reset("reset");
    preset = 1'b0;

    send(mk(32'h10, 1'b1, 32'hDEADBEEF, 4'hF, 0, 32'h0, 1'b0), 0);
    send(mk(32'h20, 1'b0, 32'hA5A5A5A5, 4'hF, 3, 32'h12345678, 1'b0), 0);
    send(mk(32'h30, 1'b1, 32'h0BADF00D, 4'h3, 1, 32'h0, 1'b1), 0);
    send(mk(32'h40, 1'b0, 32'h0, 4'h0, 20, 32'hCAFEF00D, 1'b0), 0);
    send(mk(32'h50, 1'b0, 32'h0, 4'h5, T - 1, 32'h77770007, 1'b1), 0);
    send(mk(32'h60, 1'b1, 32'h11112222, 4'hC, 0, 32'h0, 1'b0), 5);
    send(mk(32'h64, 1'b0, 32'h0, 4'h0, 0, 32'h55AA55AA, 1'b0), 0);

    for (int i = 0; i < 60; i++) begin
      r = int'($urandom_range(0, 9));
      if (r < 6)       w = int'($urandom_range(0, 3));
      else if (r == 6) w = T - 1;
      else if (r == 7) w = T;
      else if (r == 8) w = int'($urandom_range(T + 1, T + 4));
      else             w = int'($urandom_range(4, T - 2));
      send(mk($urandom, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)), w,
              $urandom, ($urandom_range(0, 3) == 0)),
           ($urandom_range(0, 9) == 0) ? 3 : 0);
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(negedge pclk);
    end
    wait_idle();

    // Reset in the middle of ACCESS drops the transfer and its response.
    send(mk(32'h80, 1'b1, 32'h89ABCDEF, 4'hF, 30, 32'h0, 1'b0), 0);
    @(negedge pclk);
    chk("pre_reset_penable", 32'(penable), 32'd1);
    preset = 1'b1;
    rst_epoch++;
    @(negedge pclk);
    preset = 1'b0;
    void'(exp_q.pop_back());
    n_drop++;
    check_reset("mid_reset");
    repeat (4) @(negedge pclk);
    send(mk(32'h90, 1'b0, 32'h0, 4'hF, 2, 32'h0F0F1234, 1'b0), 0);
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : watchdog
    #500000;
    n_tests++; n_fail++;
    $display("FAIL watchdog: got no completion by cycle %0d, expected completion", cyc);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
